// File: rtl/cnn_mul_pipe_fx_if.sv
// Handshake bundle for the pipelined fixed-point multiplier: operand side
// (in_*, din0/din1) and result side (out_*, dout/out_ovf).
interface cnn_mul_pipe_fx_if #(
    parameter int DIN0_WIDTH = 9,
    parameter int DIN1_WIDTH = 11,
    parameter int DOUT_WIDTH = 20
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  out_ovf;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, out_ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, out_ovf
    );
endinterface

// File: rtl/cnn_mul_pipe_fx.sv
// Pipelined fixed-point multiplier with valid/ready flow control, output
// alignment, optional round-half-up and wrap/saturate to DOUT_WIDTH.
module cnn_mul_pipe_fx #(
    parameter int DIN0_WIDTH  = 9,
    parameter int DIN1_WIDTH  = 11,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 3,
    parameter int FRAC_SHIFT  = 0,
    parameter int ROUND_MODE  = 0,
    parameter int SAT_MODE    = 0,
    parameter int DOUT_WIDTH  = 20
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    cnn_mul_pipe_fx_if.slave   bus
);
    localparam int P     = DIN0_WIDTH + DIN1_WIDTH;
    localparam int PW    = P + 1;
    localparam int RW    = PW + 1;
    localparam int CW    = (RW > DOUT_WIDTH + 1) ? RW : DOUT_WIDTH + 1;
    localparam bit PSIGN = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    localparam int NPS   = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
    localparam int LSRC  = (NUM_STAGE > 1) ? NUM_STAGE - 2 : 0;
    localparam int RSH   = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

    localparam logic [RW-1:0] RND_ADD =
        (ROUND_MODE == 1 && FRAC_SHIFT > 0) ? (RW'(1) << RSH) : '0;
    localparam logic signed [CW-1:0] SMAX = (CW'(1) << (DOUT_WIDTH - 1)) - CW'(1);
    localparam logic signed [CW-1:0] SMIN = -(CW'(1) << (DOUT_WIDTH - 1));
    localparam logic signed [CW-1:0] UMAX = (CW'(1) << DOUT_WIDTH) - CW'(1);

    // Every operand is widened to P+1 bits so one unsigned multiply, truncated
    // to P+1 bits, yields the exact product as a two's complement value in all
    // sign combinations (an unsigned product stays non-negative).
    logic [PW-1:0] a_ext, b_ext, prod_c;
    assign a_ext  = {{(PW-DIN0_WIDTH){(DIN0_SIGNED != 0) && bus.din0[DIN0_WIDTH-1]}}, bus.din0};
    assign b_ext  = {{(PW-DIN1_WIDTH){(DIN1_SIGNED != 0) && bus.din1[DIN1_WIDTH-1]}}, bus.din1};
    assign prod_c = a_ext * b_ext;

    logic [NUM_STAGE-1:0]  vld_q;
    logic [NUM_STAGE-1:0]  adv;
    logic [PW-1:0]         prod_q [NPS];
    logic [DOUT_WIDTH-1:0] dout_q, dout_d, sat_d;
    logic                  ovf_q, ovf_d;
    logic [PW-1:0]         last_src;
    logic                  last_vld;
    logic                  adv_acc;

    // A stage may move when any stage downstream of it (or the consumer) has room.
    always_comb begin
        adv     = '0;
        adv_acc = bus.out_ready;
        for (int i = NUM_STAGE - 1; i >= 0; i--) begin
            adv_acc = adv_acc | ~vld_q[i];
            adv[i]  = adv_acc;
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = vld_q[NUM_STAGE-1];
    assign bus.dout      = dout_q;
    assign bus.out_ovf   = ovf_q;

    assign last_src = (NUM_STAGE == 1) ? prod_c : prod_q[NPS-1];
    assign last_vld = (NUM_STAGE == 1) ? bus.in_valid : vld_q[LSRC];

    logic signed [RW-1:0] rnd_d, shf_d;
    logic signed [CW-1:0] ext_d;

    always_comb begin
        rnd_d = $signed({last_src[PW-1], last_src}) + $signed(RND_ADD);
        shf_d = rnd_d >>> FRAC_SHIFT;
        ext_d = CW'(shf_d);
        if (PSIGN) begin
            ovf_d = (ext_d > SMAX) || (ext_d < SMIN);
            sat_d = ext_d[CW-1] ? SMIN[DOUT_WIDTH-1:0] : SMAX[DOUT_WIDTH-1:0];
        end else begin
            ovf_d = ext_d > UMAX;
            sat_d = UMAX[DOUT_WIDTH-1:0];
        end
        dout_d = (ovf_d && SAT_MODE != 0) ? sat_d : ext_d[DOUT_WIDTH-1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < NPS; i++) prod_q[i] <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (adv[0]) vld_q[0] <= bus.in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                if (adv[i]) vld_q[i] <= vld_q[i-1];
            end
            if (NUM_STAGE > 1 && adv[0] && bus.in_valid) prod_q[0] <= prod_c;
            for (int i = 1; i < NUM_STAGE - 1; i++) begin
                if (adv[i] && vld_q[i-1]) prod_q[i] <= prod_q[i-1];
            end
            if (adv[NUM_STAGE-1] && last_vld) begin
                dout_q <= dout_d;
                ovf_q  <= ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_cnn_mul_pipe_fx.sv
// Scoreboard bench for cnn_mul_pipe_fx: one default instance for latency,
// streaming/backpressure and reset, plus signed/rounding/saturation variants.
module tb_cnn_mul_pipe_fx;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [20:0] exq [6][$];
    logic        hold_vld = 1'b0;
    logic [20:0] hold_val = '0;

    cnn_mul_pipe_fx_if #(.DOUT_WIDTH(20)) m_if   ();
    cnn_mul_pipe_fx_if #(.DOUT_WIDTH(16)) sat_if ();
    cnn_mul_pipe_fx_if #(.DOUT_WIDTH(16)) wrp_if ();
    cnn_mul_pipe_fx_if #(.DOUT_WIDTH(20)) rnd_if ();
    cnn_mul_pipe_fx_if #(.DOUT_WIDTH(20)) trn_if ();
    cnn_mul_pipe_fx_if #(.DOUT_WIDTH(20)) mx_if  ();

    cnn_mul_pipe_fx u_main (.ap_clk(clk), .ap_rst_n(rst_n), .bus(m_if));
    cnn_mul_pipe_fx #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .SAT_MODE(1), .DOUT_WIDTH(16))
        u_sat (.ap_clk(clk), .ap_rst_n(rst_n), .bus(sat_if));
    cnn_mul_pipe_fx #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .SAT_MODE(0), .DOUT_WIDTH(16))
        u_wrp (.ap_clk(clk), .ap_rst_n(rst_n), .bus(wrp_if));
    cnn_mul_pipe_fx #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .FRAC_SHIFT(4), .ROUND_MODE(1))
        u_rnd (.ap_clk(clk), .ap_rst_n(rst_n), .bus(rnd_if));
    cnn_mul_pipe_fx #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .FRAC_SHIFT(4), .ROUND_MODE(0))
        u_trn (.ap_clk(clk), .ap_rst_n(rst_n), .bus(trn_if));
    cnn_mul_pipe_fx #(.DIN0_SIGNED(1), .DIN1_SIGNED(0))
        u_mx (.ap_clk(clk), .ap_rst_n(rst_n), .bus(mx_if));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic sb_pop(input int k, input string tag, input logic [20:0] act);
        chk({tag, "_expected"}, 32'(exq[k].size() != 0), 32'd1);
        if (exq[k].size() != 0) chk(tag, 32'(act), 32'(exq[k].pop_front()));
    endtask

    function automatic int q_total();
        int t = 0;
        for (int k = 0; k < 6; k++) t += exq[k].size();
        return t;
    endfunction

    task automatic wait_drain(input string tag);
        int n = 0;
        while (q_total() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(q_total()), 32'd0);
    endtask

    // Operand and {ovf, dout} expectation for one auxiliary instance.
    task automatic aux_set(input int k, input logic [8:0] a, input logic [10:0] b,
                           input logic [20:0] e);
        case (k)
            1: begin sat_if.in_valid = 1'b1; sat_if.din0 = a; sat_if.din1 = b; end
            2: begin wrp_if.in_valid = 1'b1; wrp_if.din0 = a; wrp_if.din1 = b; end
            3: begin rnd_if.in_valid = 1'b1; rnd_if.din0 = a; rnd_if.din1 = b; end
            4: begin trn_if.in_valid = 1'b1; trn_if.din0 = a; trn_if.din1 = b; end
            default: begin mx_if.in_valid = 1'b1; mx_if.din0 = a; mx_if.din1 = b; end
        endcase
        exq[k].push_back(e);
    endtask

    task automatic aux_idle();
        sat_if.in_valid = 1'b0; wrp_if.in_valid = 1'b0; rnd_if.in_valid = 1'b0;
        trn_if.in_valid = 1'b0; mx_if.in_valid  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) exq[k].delete();
            hold_vld = 1'b0;
        end else begin
            if (m_if.in_valid && m_if.in_ready)
                exq[0].push_back({1'b0, 20'(int'(m_if.din0) * int'(m_if.din1))});
            if (m_if.out_valid) begin
                if (hold_vld) chk("stall_hold", 32'({m_if.out_ovf, m_if.dout}), 32'(hold_val));
                hold_vld = !m_if.out_ready;
                hold_val = {m_if.out_ovf, m_if.dout};
                if (m_if.out_ready) sb_pop(0, "main", {m_if.out_ovf, m_if.dout});
            end else begin
                hold_vld = 1'b0;
            end
            if (sat_if.out_valid) sb_pop(1, "sat16", {sat_if.out_ovf, 4'h0, sat_if.dout});
            if (wrp_if.out_valid) sb_pop(2, "wrap16", {wrp_if.out_ovf, 4'h0, wrp_if.dout});
            if (rnd_if.out_valid) sb_pop(3, "round", {rnd_if.out_ovf, rnd_if.dout});
            if (trn_if.out_valid) sb_pop(4, "trunc", {trn_if.out_ovf, trn_if.dout});
            if (mx_if.out_valid)  sb_pop(5, "mixed", {mx_if.out_ovf, mx_if.dout});
        end
    end

    initial begin
        int  idx;
        int  cyc;
        logic acc;
        rst_n = 1'b0;
        m_if.in_valid = 1'b0; m_if.din0 = '0; m_if.din1 = '0; m_if.out_ready = 1'b1;
        aux_idle();
        sat_if.din0 = '0; sat_if.din1 = '0; sat_if.out_ready = 1'b1;
        wrp_if.din0 = '0; wrp_if.din1 = '0; wrp_if.out_ready = 1'b1;
        rnd_if.din0 = '0; rnd_if.din1 = '0; rnd_if.out_ready = 1'b1;
        trn_if.din0 = '0; trn_if.din1 = '0; trn_if.out_ready = 1'b1;
        mx_if.din0  = '0; mx_if.din1  = '0; mx_if.out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(m_if.out_valid), 32'd0);
        chk("rst_in_ready",  32'(m_if.in_ready),  32'd1);
        chk("rst_dout",      32'(m_if.dout),      32'd0);
        chk("rst_ovf",       32'(m_if.out_ovf),   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-scale unsigned product and its latency.
        m_if.in_valid = 1'b1; m_if.din0 = 9'd511; m_if.din1 = 11'd2047;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        chk("lat_edge0", 32'(m_if.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge1", 32'(m_if.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 32'(m_if.out_valid), 32'd1);
        chk("max_dout",  32'(m_if.dout),      32'h000FF601);
        chk("max_ovf",   32'(m_if.out_ovf),   32'd0);
        wait_drain("drain_max");

        // Signed saturation/wrap, rounding vs truncation, mixed signedness.
        aux_set(1, -9'sd256, -11'sd1024, {1'b1, 20'h07FFF});
        aux_set(2, -9'sd256, -11'sd1024, {1'b1, 20'h00000});
        aux_set(3, -9'sd1,   11'sd8,     {1'b0, 20'h00000});
        aux_set(4, -9'sd1,   11'sd8,     {1'b0, 20'hFFFFF});
        aux_set(5, -9'sd1,   11'd2047,   {1'b0, 20'hFF801});
        @(posedge clk); #1;
        aux_set(1, -9'sd256, 11'sd1023,  {1'b1, 20'h08000});
        aux_set(2, -9'sd256, 11'sd1023,  {1'b1, 20'h00100});
        aux_set(3, 9'sd3,    11'sd5,     {1'b0, 20'h00001});
        aux_set(4, 9'sd3,    11'sd5,     {1'b0, 20'h00000});
        aux_set(5, -9'sd256, 11'd2047,   {1'b0, 20'h80100});
        @(posedge clk); #1;
        aux_set(1, 9'sd3,    11'sd5,     {1'b0, 20'h0000F});
        aux_set(2, 9'sd3,    11'sd5,     {1'b0, 20'h0000F});
        aux_set(3, -9'sd1,   -11'sd8,    {1'b0, 20'h00001});
        aux_set(4, -9'sd1,   -11'sd8,    {1'b0, 20'h00000});
        aux_set(5, 9'sd255,  11'd2047,   {1'b0, 20'h7F701});
        @(posedge clk); #1;
        aux_idle();
        wait_drain("drain_aux");

        // Back-to-back stream with a 5-cycle consumer stall.
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 100) begin
            m_if.in_valid  = 1'b1;
            m_if.din0      = 9'(idx);
            m_if.din1      = 11'd3;
            m_if.out_ready = !(cyc >= 4 && cyc < 9);
            @(negedge clk);
            acc = m_if.in_ready;
            if (cyc >= 5 && cyc < 9) chk("full_in_ready", 32'(m_if.in_ready), 32'd0);
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        chk("stream_cycles", 32'(cyc), 32'd15);
        wait_drain("drain_stream");
        chk("drained_out_valid", 32'(m_if.out_valid), 32'd0);

        // Three samples in flight, then an asynchronous reset pulse.
        m_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_if.in_valid = 1'b1; m_if.din0 = 9'(7 + i); m_if.din1 = 11'd9;
            @(posedge clk); #1;
        end
        m_if.in_valid = 1'b0;
        chk("inflight_valid", 32'(m_if.out_valid), 32'd1);
        chk("inflight_ready", 32'(m_if.in_ready),  32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(m_if.out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_if.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_quiet", 32'(m_if.out_valid), 32'd0);
        m_if.in_valid = 1'b1; m_if.din0 = 9'd13; m_if.din1 = 11'd17;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        wait_drain("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
